// File: rtl/noise_meter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// noise_meter_pkg : shared types and helpers for the noise pulse meter
// Rev 1.0
// ----------------------------------------------------------------------------
package noise_meter_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

    // Widest supported measurement; narrower all-ones values are sliced from this.
    localparam logic [63:0] c_all_ones = '1;

    // True when a counter of the given width is already at its saturation value.
    function automatic logic sat_at_max(input logic [63:0] value, input int unsigned width);
        return value == (c_all_ones >> (64 - width));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_sync_edge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pulse_sync_edge : 2-FF synchronizer with registered rise/fall strobes
// Rev 1.0
// ----------------------------------------------------------------------------
module pulse_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // level is the delayed copy so it lines up with the rise/fall strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            r_meta <= pulse_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
            rise   <= r_sync & ~r_prev;
            fall   <= ~r_sync & r_prev;
        end
    end

    assign level = r_prev;

endmodule
`default_nettype wire

// File: rtl/noise_pulse_meter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// noise_pulse_meter : gated edge count, min/max gap and longest high time
// Rev 1.0
// ----------------------------------------------------------------------------
module noise_pulse_meter
    import noise_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned GAP_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] pulse_count,
    output logic [GAP_W-1:0] min_gap,
    output logic [GAP_W-1:0] max_gap,
    output logic [GAP_W-1:0] max_high,
    output logic             overflow,
    output logic             result_valid
);

    localparam int unsigned       GATE_W      = $clog2(GATE_CYCLES);
    localparam logic [GAP_W-1:0]  c_gap_ones  = c_all_ones[GAP_W-1:0];
    localparam logic [GATE_W-1:0] c_gate_last = GATE_W'(GATE_CYCLES - 1);

    logic w_level;
    logic w_rise;
    logic w_fall;

    pulse_sync_edge u_sync (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .level    (w_level),
        .rise     (w_rise),
        .fall     (w_fall)
    );

    meter_state_t      r_state;
    logic [GATE_W-1:0] r_gate;
    logic [CNT_W-1:0]  r_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [GAP_W-1:0]  r_min;
    logic [GAP_W-1:0]  r_max;
    logic [GAP_W-1:0]  r_high_cnt;
    logic [GAP_W-1:0]  r_max_high;
    logic              r_seen;
    logic              r_ovf;

    logic              w_terminal;
    logic              w_cnt_full;
    logic              w_gap_full;
    logic              w_high_full;
    logic [CNT_W-1:0]  w_cnt;
    logic [GAP_W-1:0]  w_min;
    logic [GAP_W-1:0]  w_max;
    logic [GAP_W-1:0]  w_max_high;
    logic [GAP_W-1:0]  w_gap_next;
    logic [GAP_W-1:0]  w_high_next;
    logic              w_ovf;

    // Working values including this cycle's events, so a terminal-cycle event
    // lands in the ending window.
    always_comb begin
        w_terminal  = (r_gate == c_gate_last);
        w_cnt_full  = sat_at_max(64'(r_cnt), CNT_W);
        w_gap_full  = sat_at_max(64'(r_gap_cnt), GAP_W);
        w_high_full = sat_at_max(64'(r_high_cnt), GAP_W);

        w_cnt = r_cnt;
        if (w_rise && !w_cnt_full) begin
            w_cnt = r_cnt + 1'b1;
        end

        w_min = r_min;
        w_max = r_max;
        if (w_rise && r_seen) begin
            if (r_gap_cnt < r_min) w_min = r_gap_cnt;
            if (r_gap_cnt > r_max) w_max = r_gap_cnt;
        end

        w_max_high = (w_fall && (r_high_cnt > r_max_high)) ? r_high_cnt : r_max_high;

        w_ovf = r_ovf | (w_rise & w_cnt_full) | (r_seen & ~w_rise & w_gap_full)
              | (w_level & ~w_rise & w_high_full);

        if (w_rise)                      w_gap_next = GAP_W'(1);
        else if (r_seen && !w_gap_full)  w_gap_next = r_gap_cnt + 1'b1;
        else                             w_gap_next = r_gap_cnt;

        if (w_rise)                       w_high_next = GAP_W'(1);
        else if (w_level && !w_high_full) w_high_next = r_high_cnt + 1'b1;
        else                              w_high_next = r_high_cnt;
    end

    // High-run counter spans windows; a run is credited where it falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_gate       <= '0;
            r_cnt        <= '0;
            r_gap_cnt    <= '0;
            r_min        <= c_gap_ones;
            r_max        <= '0;
            r_high_cnt   <= '0;
            r_max_high   <= '0;
            r_seen       <= 1'b0;
            r_ovf        <= 1'b0;
            pulse_count  <= '0;
            min_gap      <= c_gap_ones;
            max_gap      <= '0;
            max_high     <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            r_high_cnt   <= w_high_next;
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_state    <= MEASURE;
                        r_gate     <= '0;
                        r_cnt      <= '0;
                        r_gap_cnt  <= '0;
                        r_min      <= c_gap_ones;
                        r_max      <= '0;
                        r_max_high <= '0;
                        r_seen     <= 1'b0;
                        r_ovf      <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (!en) begin
                        r_state <= IDLE;
                    end else if (w_terminal) begin
                        pulse_count  <= w_cnt;
                        min_gap      <= w_min;
                        max_gap      <= w_max;
                        max_high     <= w_max_high;
                        overflow     <= w_ovf;
                        result_valid <= 1'b1;
                        r_gate       <= '0;
                        r_cnt        <= '0;
                        r_gap_cnt    <= '0;
                        r_min        <= c_gap_ones;
                        r_max        <= '0;
                        r_max_high   <= '0;
                        r_seen       <= 1'b0;
                        r_ovf        <= 1'b0;
                    end else begin
                        r_gate     <= r_gate + 1'b1;
                        r_cnt      <= w_cnt;
                        r_gap_cnt  <= w_gap_next;
                        r_min      <= w_min;
                        r_max      <= w_max;
                        r_max_high <= w_max_high;
                        r_seen     <= r_seen | w_rise;
                        r_ovf      <= w_ovf;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_noise_pulse_meter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_noise_pulse_meter : directed self-checking bench, 100-cycle gate window
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_noise_pulse_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        pulse_in;
    logic [15:0] pulse_count, min_gap, max_gap, max_high;
    logic        overflow, result_valid;
    logic [3:0]  pulse_count4;
    logic [15:0] min_gap4, max_gap4, max_high4;
    logic        overflow4, result_valid4;

    noise_pulse_meter #(.GATE_CYCLES(100), .CNT_W(16), .GAP_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .pulse_in(pulse_in),
        .pulse_count(pulse_count), .min_gap(min_gap), .max_gap(max_gap),
        .max_high(max_high), .overflow(overflow), .result_valid(result_valid)
    );

    noise_pulse_meter #(.GATE_CYCLES(100), .CNT_W(4), .GAP_W(16)) dut4 (
        .clk(clk), .rst(rst), .en(en), .pulse_in(pulse_in),
        .pulse_count(pulse_count4), .min_gap(min_gap4), .max_gap(max_gap4),
        .max_high(max_high4), .overflow(overflow4), .result_valid(result_valid4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] cnt;
        logic [15:0] mn;
        logic [15:0] mx;
        logic [15:0] mh;
        logic        ovf;
    } res_t;

    res_t q[$];
    res_t q4[$];
    res_t mon_r;
    res_t mon_r4;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    // Strobe recorder: every published result with the negedge index it was seen on.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (result_valid === 1'b1) begin
            mon_r.cyc = cyc; mon_r.cnt = pulse_count; mon_r.mn = min_gap;
            mon_r.mx = max_gap; mon_r.mh = max_high; mon_r.ovf = overflow;
            q.push_back(mon_r);
        end
        if (result_valid4 === 1'b1) begin
            mon_r4.cyc = cyc; mon_r4.cnt = 16'(pulse_count4); mon_r4.mn = min_gap4;
            mon_r4.mx = max_gap4; mon_r4.mh = max_high4; mon_r4.ovf = overflow4;
            q4.push_back(mon_r4);
        end
    end

    function automatic logic [64:0] pack(input res_t r);
        return {r.cnt, r.mn, r.mx, r.mh, r.ovf};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; pulse_in = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; pulse_in = 1'b0;
        tick(); tick();
        checks++;
        if ({pulse_count, min_gap, max_gap, max_high, overflow} !== {16'd0, 16'hFFFF, 16'd0, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got %h want %h", {pulse_count, min_gap, max_gap, max_high, overflow},
                     {16'd0, 16'hFFFF, 16'd0, 16'd0, 1'b0});
        end
        checks++;
        if (result_valid !== 1'b0) begin
            errors++; $display("FAIL reset_strobe: got %b want 0", result_valid);
        end
        checks++;
        if ({pulse_count4, min_gap4, overflow4} !== {4'd0, 16'hFFFF, 1'b0}) begin
            errors++; $display("FAIL reset_outputs4: got %h want %h", {pulse_count4, min_gap4, overflow4}, {4'd0, 16'hFFFF, 1'b0});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_periodic();
        int b, k;
        do_reset();
        b = q.size(); k = cyc;
        for (int i = 0; i < 305; i++) begin
            en = 1'b1;
            pulse_in = (i >= 5) && ((i - 5) % 10 < 3);
            tick();
        end
        checks++;
        if (q.size() - b !== 3) begin
            errors++; $display("FAIL periodic_strobes: got %0d want 3", q.size() - b);
        end else begin
            checks++;
            if (q[b].cyc !== k + 102) begin
                errors++; $display("FAIL periodic_first_time: got %0d want %0d", q[b].cyc, k + 102);
            end
            checks++;
            if (q[b+2].cyc - q[b+1].cyc !== 100) begin
                errors++; $display("FAIL periodic_interval: got %0d want 100", q[b+2].cyc - q[b+1].cyc);
            end
            for (int w = 0; w < 3; w++) begin
                checks++;
                if (pack(q[b+w]) !== {16'd10, 16'd10, 16'd10, 16'd3, 1'b0}) begin
                    errors++; $display("FAIL periodic_window%0d: got %h want %h", w, pack(q[b+w]),
                                       {16'd10, 16'd10, 16'd10, 16'd3, 1'b0});
                end
            end
        end
    endtask

    task automatic test_idle_line();
        int b, k;
        do_reset();
        b = q.size(); k = cyc;
        for (int i = 0; i < 105; i++) begin
            en = 1'b1; pulse_in = 1'b0;
            tick();
        end
        checks++;
        if (q.size() - b !== 1) begin
            errors++; $display("FAIL idle_strobes: got %0d want 1", q.size() - b);
        end else begin
            checks++;
            if (q[b].cyc !== k + 102) begin
                errors++; $display("FAIL idle_time: got %0d want %0d", q[b].cyc, k + 102);
            end
            checks++;
            if (pack(q[b]) !== {16'd0, 16'hFFFF, 16'd0, 16'd0, 1'b0}) begin
                errors++; $display("FAIL idle_values: got %h want %h", pack(q[b]), {16'd0, 16'hFFFF, 16'd0, 16'd0, 1'b0});
            end
        end
    endtask

    task automatic test_mixed_gaps();
        int b, m;
        logic [64:0] exp_w [3];
        exp_w[0] = {16'd9, 16'd7, 16'd20, 16'd2, 1'b0};
        exp_w[1] = {16'd7, 16'd7, 16'd20, 16'd2, 1'b0};
        exp_w[2] = {16'd8, 16'd7, 16'd20, 16'd2, 1'b0};
        do_reset();
        b = q.size();
        for (int i = 0; i < 305; i++) begin
            m = i % 39;
            en = 1'b1;
            pulse_in = (m == 0 || m == 1 || m == 7 || m == 8 || m == 19 || m == 20);
            tick();
        end
        checks++;
        if (q.size() - b !== 3) begin
            errors++; $display("FAIL gaps_strobes: got %0d want 3", q.size() - b);
        end else begin
            for (int w = 0; w < 3; w++) begin
                checks++;
                if (pack(q[b+w]) !== exp_w[w]) begin
                    errors++; $display("FAIL gaps_window%0d: got %h want %h", w, pack(q[b+w]), exp_w[w]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int b, b4;
        do_reset();
        b = q.size(); b4 = q4.size();
        for (int i = 0; i < 205; i++) begin
            en = 1'b1;
            if (i < 100) pulse_in = (i % 5 < 2);
            else         pulse_in = (i == 110 || i == 111 || i == 130 || i == 131 || i == 150 || i == 151);
            tick();
        end
        checks++;
        if (q4.size() - b4 !== 2 || q.size() - b !== 2) begin
            errors++; $display("FAIL sat_strobes: got %0d/%0d want 2/2", q4.size() - b4, q.size() - b);
        end else begin
            checks++;
            if (pack(q4[b4]) !== {16'd15, 16'd5, 16'd5, 16'd2, 1'b1}) begin
                errors++; $display("FAIL sat_cnt4_full: got %h want %h", pack(q4[b4]), {16'd15, 16'd5, 16'd5, 16'd2, 1'b1});
            end
            checks++;
            if (pack(q4[b4+1]) !== {16'd3, 16'd20, 16'd20, 16'd2, 1'b0}) begin
                errors++; $display("FAIL sat_cnt4_after: got %h want %h", pack(q4[b4+1]), {16'd3, 16'd20, 16'd20, 16'd2, 1'b0});
            end
            checks++;
            if (pack(q[b]) !== {16'd20, 16'd5, 16'd5, 16'd2, 1'b0}) begin
                errors++; $display("FAIL sat_cnt16: got %h want %h", pack(q[b]), {16'd20, 16'd5, 16'd5, 16'd2, 1'b0});
            end
        end
    endtask

    task automatic test_abort();
        int b, k2;
        do_reset();
        b = q.size(); k2 = 0;
        for (int i = 0; i < 415; i++) begin
            en = !(i >= 150 && i < 300);
            pulse_in = (i >= 5) && ((i - 5) % 10 < 3);
            if (i == 300) k2 = cyc;
            if (i == 299) begin
                checks++;
                if (q.size() - b !== 1) begin
                    errors++; $display("FAIL abort_no_strobe: got %0d strobes want 1", q.size() - b);
                end
                checks++;
                if ({pulse_count, min_gap, max_gap, max_high, overflow} !== {16'd10, 16'd10, 16'd10, 16'd3, 1'b0}) begin
                    errors++; $display("FAIL abort_hold: got %h want %h", {pulse_count, min_gap, max_gap, max_high, overflow},
                                       {16'd10, 16'd10, 16'd10, 16'd3, 1'b0});
                end
            end
            tick();
        end
        checks++;
        if (q.size() - b !== 2) begin
            errors++; $display("FAIL abort_restart_strobes: got %0d want 2", q.size() - b);
        end else begin
            checks++;
            if (q[b+1].cyc !== k2 + 102) begin
                errors++; $display("FAIL abort_restart_time: got %0d want %0d", q[b+1].cyc, k2 + 102);
            end
            checks++;
            if (pack(q[b+1]) !== {16'd10, 16'd10, 16'd10, 16'd3, 1'b0}) begin
                errors++; $display("FAIL abort_restart_values: got %h want %h", pack(q[b+1]), {16'd10, 16'd10, 16'd10, 16'd3, 1'b0});
            end
        end
    endtask

    task automatic test_mid_reset();
        int b, k3;
        do_reset();
        b = q.size(); k3 = 0;
        for (int i = 0; i < 280; i++) begin
            en = 1'b1;
            rst = (i == 160 || i == 161);
            pulse_in = (i >= 5) && ((i - 5) % 10 < 3);
            if (i == 162) k3 = cyc;
            tick();
            if (i == 161) begin
                checks++;
                if ({pulse_count, min_gap, max_gap, max_high, overflow, result_valid} !==
                    {16'd0, 16'hFFFF, 16'd0, 16'd0, 1'b0, 1'b0}) begin
                    errors++; $display("FAIL midreset_outputs: got %h want %h",
                                       {pulse_count, min_gap, max_gap, max_high, overflow, result_valid},
                                       {16'd0, 16'hFFFF, 16'd0, 16'd0, 1'b0, 1'b0});
                end
            end
        end
        checks++;
        if (q.size() - b !== 2) begin
            errors++; $display("FAIL midreset_strobes: got %0d want 2", q.size() - b);
        end else begin
            checks++;
            if (q[b+1].cyc !== k3 + 102) begin
                errors++; $display("FAIL midreset_time: got %0d want %0d", q[b+1].cyc, k3 + 102);
            end
            checks++;
            if (pack(q[b+1]) !== {16'd10, 16'd10, 16'd10, 16'd3, 1'b0}) begin
                errors++; $display("FAIL midreset_values: got %h want %h", pack(q[b+1]), {16'd10, 16'd10, 16'd10, 16'd3, 1'b0});
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; pulse_in = 1'b0;
        test_reset();
        test_periodic();
        test_idle_line();
        test_mixed_gaps();
        test_saturation();
        test_abort();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noise_pulse_meter.md
Name: noise_pulse_meter

Overview:
- Receive-side companion to the noise pulse generator: measures the random pulse train that block emits.
- Loopback or external pin input.
- Per fixed gate window, reports rising-edge count, min/max inter-edge gap and longest high time, with a one-cycle result strobe.
- Sits on the main system clock and feeds the display/readout logic.

Parameters:
- GATE_CYCLES, 50000000, window length in clk cycles (1 s at 50 MHz); must be >= 4.
- CNT_W, 16, width of pulse_count.
- GAP_W, 16, width of gap and high-width measurements.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  measurement enable; level-sensitive.
- pulse_in  in  1  asynchronous pulse train under test.
- pulse_count  out  CNT_W  rising edges in the last completed window (saturating).
- min_gap  out  GAP_W  smallest rising-to-rising interval in cycles; all-ones if fewer than 2 edges.
- max_gap  out  GAP_W  largest rising-to-rising interval; 0 if fewer than 2 edges.
- max_high  out  GAP_W  longest high run in cycles ending in the window; 0 if none.
- overflow  out  1  count or any width measurement saturated during the window.
- result_valid  out  1  one-cycle strobe; outputs updated on the same edge.

Behaviour:
- Reset
  - All outputs 0, except min_gap, which is all-ones.
  - FSM goes to IDLE; all counters and synchronizer flops clear.
- Input path
  - pulse_in passes through a 2-FF synchronizer, then an edge-detect register.
  - A rising or falling event is flagged 3 cycles after the pin transition.
  - All measurements use the synchronized signal.
- FSM states: IDLE, MEASURE.
  - IDLE -> MEASURE when en=1. The gate counter loads 0, working accumulators clear, and no edge has been seen yet.
  - MEASURE -> IDLE when en=0 (abort). No result_valid; published outputs keep their previous values.
  - In MEASURE, the gate counter increments each cycle. At count GATE_CYCLES-1 (terminal cycle):
    - Working values copy to the outputs on the next edge, and result_valid pulses high for 1 cycle.
    - The next window starts immediately with accumulators cleared. There is no dead cycle.
- Edge count
  - Increments on each rising event, saturating at 2^CNT_W-1.
  - A saturating increment sets the window's overflow flag.
- Gap
  - A gap counter runs from each rising event.
  - On a subsequent rising event in the same window, the counter value (cycles between events) updates min/max, then the counter restarts.
  - The first rising event of a window only starts the counter. Gaps never span windows.
  - The gap counter saturates at all-ones and sets overflow; a saturated gap is still compared.
- High width
  - Counts cycles while the synchronized signal is high, starting at the rising event.
  - On the falling event the length updates max_high.
  - This counter is not cleared at a window boundary: a run is credited with its full length to the window containing its falling event.
  - A run still high at the terminal cycle is not reported in that window. Saturation sets overflow.
- Simultaneous events
  - An event on the terminal cycle is counted in the ending window.
  - An event on the first cycle of a new window belongs to the new window.
- en=1 in the same cycle as a reset release: the FSM enters MEASURE on the first clock after rst deasserts.
- Reset mid-window: immediate return to the reset state; no strobe.

Decomposition:
- Package noise_meter_pkg: FSM state enum (IDLE, MEASURE); constant for the all-ones gap reset value; helper function for saturating increment.
- Sub-module pulse_sync_edge: 2-FF synchronizer plus registered rise/fall strobes. One instance.

Test Plan (GATE_CYCLES=100, CNT_W=16, GAP_W=16 unless stated):
1. en=1; pulse_in period 10, high 3, first rise 5 cycles after en -> each window: pulse_count=10, min_gap=max_gap=10, max_high=3, overflow=0, result_valid every 100 cycles.
2. pulse_in held low, en=1 -> pulse_count=0, min_gap=16'hFFFF, max_gap=0, max_high=0, result_valid at cycle 100.
3. Gaps 7, 12 and 20 cycles alternating, high 2 -> min_gap=7, max_gap=20, max_high=2.
4. CNT_W=4, 20 rises per window (period 5) -> pulse_count=15, overflow=1; the next window with 3 rises reports 3 with overflow=0.
5. en dropped at window cycle 50 -> no result_valid and outputs unchanged; en reasserted -> a fresh 100-cycle window, result at +100.
6. rst pulsed at window cycle 60 -> all outputs at reset values and min_gap=all-ones; no strobe until 100 cycles after the first clock with rst low and en=1.
